// File: rtl/regfile.sv
// orion integer register file: zero-fill after reset,
// WB write bypass and per-register pending-writer counts
package orion_types;
  localparam int XLEN = 32;
  localparam int RF_IDX_BITS = 5;

  typedef struct packed {
    logic                   rd_we;
    logic [RF_IDX_BITS-1:0] rd_s;
    logic [XLEN-1:0]        rd_v;
  } wb_id_t;
endpackage

module regfile #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int CNT_BITS = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  orion_types::wb_id_t    wb_id_i,
  input  logic [orion_types::RF_IDX_BITS-1:0] rs1_s_i,
  input  logic [orion_types::RF_IDX_BITS-1:0] rs2_s_i,
  output logic [XLEN-1:0]        rs1_v_o,
  output logic [XLEN-1:0]        rs2_v_o,
  input  logic                   issue_we_i,
  input  logic [orion_types::RF_IDX_BITS-1:0] issue_rd_s_i,
  output logic                   rs1_busy_o,
  output logic                   rs2_busy_o,
  output logic                   ready_o,
  output logic                   sb_err_o
);

  localparam int IW = orion_types::RF_IDX_BITS;
  localparam logic [CNT_BITS-1:0] CMAX = '1;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t state, state_d;

  logic [IW-1:0] init_idx, init_idx_d;

  logic [XLEN-1:0] mem [NREGS];

  logic [CNT_BITS-1:0] cnt   [NREGS];
  logic [CNT_BITS-1:0] cnt_d [NREGS];
  logic                err_d;

  logic run;
  logic wb_go;
  logic iss_go;
  logic hit1;
  logic hit2;

  assign run = (state == RUN);

  assign wb_go = run && wb_id_i.rd_we
              && (wb_id_i.rd_s != '0);

  assign iss_go = run && issue_we_i
               && (issue_rd_s_i != '0);

  assign hit1 = wb_go && (wb_id_i.rd_s == rs1_s_i);
  assign hit2 = wb_go && (wb_id_i.rd_s == rs2_s_i);

  // Zero-fill sweep in INIT, then park in RUN
  always_comb begin
    state_d    = state;
    init_idx_d = init_idx;
    ready_o    = 1'b0;
    unique case (state)
      INIT: begin
        init_idx_d = init_idx + IW'(1);
        if (init_idx == IW'(NREGS - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        ready_o = 1'b1;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // FSM state and fill pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= INIT;
      init_idx <= '0;
    end else begin
      state    <= state_d;
      init_idx <= init_idx_d;
    end
  end

  // Single write port: fill zeros, then WB commits
  always_ff @(posedge clk_i) begin
    if (!run) begin
      mem[init_idx] <= '0;
    end else if (wb_go) begin
      mem[wb_id_i.rd_s] <= wb_id_i.rd_v;
    end
  end

  // Pending-writer counts; saturate and flag on misuse
  always_comb begin
    cnt_d = cnt;
    err_d = sb_err_o;
    for (int i = 1; i < NREGS; i++) begin
      unique case ({iss_go && (issue_rd_s_i == IW'(i)),
                    wb_go && (wb_id_i.rd_s == IW'(i))})
        2'b10: begin
          if (cnt[i] == CMAX) begin
            err_d = 1'b1;
          end else begin
            cnt_d[i] = cnt[i] + CNT_BITS'(1);
          end
        end
        2'b01: begin
          if (cnt[i] == '0) begin
            err_d = 1'b1;
          end else begin
            cnt_d[i] = cnt[i] - CNT_BITS'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Scoreboard state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        cnt[i] <= '0;
      end
      sb_err_o <= 1'b0;
    end else begin
      cnt      <= cnt_d;
      sb_err_o <= err_d;
    end
  end

  assign rs1_v_o = (!run || rs1_s_i == '0) ? '0
                 : hit1 ? wb_id_i.rd_v
                 : mem[rs1_s_i];

  assign rs2_v_o = (!run || rs2_s_i == '0) ? '0
                 : hit2 ? wb_id_i.rd_v
                 : mem[rs2_s_i];

  assign rs1_busy_o = run && (rs1_s_i != '0)
    && (hit1 ? (cnt[rs1_s_i] > CNT_BITS'(1))
             : (cnt[rs1_s_i] != '0));

  assign rs2_busy_o = run && (rs2_s_i != '0)
    && (hit2 ? (cnt[rs2_s_i] > CNT_BITS'(1))
             : (cnt[rs2_s_i] != '0));

endmodule
